pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/squash sequencer for the 5-stage in-order RV32I pipeline. It drives hold and bubble controls for the IF, ID and MEM stage registers, and its outputs feed the decode stage's stall/squash inputs. It detects load-use and control-operand hazards and sequences multi-cycle data-memory waits through a request/valid handshake. It also runs a post-reset flush and a memory-wait watchdog.

Parameters:
RST_FLUSH_CYCLES, 2, cycles after reset release during which the pipeline is held flushed (1..15)
MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before the watchdog fires (1..2^16-1)
PERF_CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  clock
rst_ni  in  1  synchronous active-low reset
id_valid_i  in  1  ID holds a valid instruction
id_rs1_addr_i  in  5  ID rs1 index
id_rs2_addr_i  in  5  ID rs2 index
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_used_i  in  1  ID instruction reads rs2
id_ctrl_i  in  1  ID instruction is a branch or JALR (resolved in ID)
id_redirect_i  in  1  ID asserts JAL, JALR or taken branch
ex_valid_i  in  1  ID/EX register valid
ex_rd_addr_i  in  5  ID/EX destination
ex_reg_wr_en_i  in  1  ID/EX writes the register file
ex_dmem_rd_en_i  in  1  ID/EX is a load
mem_valid_i  in  1  EX/MEM register valid
mem_rd_addr_i  in  5  EX/MEM destination
mem_dmem_rd_en_i  in  1  EX/MEM is a load
mem_req_i  in  1  MEM stage issues a dmem request this cycle
dmem_rvalid_i  in  1  dmem response or write acknowledge
stall_if_o  out  1  hold PC and the IF/ID register
squash_if_o  out  1  invalidate the IF/ID register
stall_id_o  out  1  hold the ID/EX register (decode stall_i)
squash_id_o  out  1  insert a bubble into ID/EX (decode squash_i)
stall_mem_o  out  1  hold EX/MEM and MEM/WB
mem_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset: rst_ni sampled low at posedge -> state FLUSH, flush_cnt = RST_FLUSH_CYCLES, wd_cnt = 0, mem_timeout_o = 0.
- States: FLUSH, RUN, MEM_WAIT. Outputs are combinational from the state plus inputs.
- FLUSH: stall_if_o=1, squash_if_o=1, squash_id_o=1, stall_id_o=0, stall_mem_o=0. flush_cnt decrements each cycle; when it reaches 1 the next state is RUN. The FLUSH state lasts exactly RST_FLUSH_CYCLES cycles.
- RUN to MEM_WAIT: mem_valid_i && mem_req_i && !dmem_rvalid_i. A same-cycle rvalid is a zero-wait access, and the state stays RUN.
- MEM_WAIT: stall_if_o = stall_id_o = stall_mem_o = 1. All squashes are 0. All hazard and redirect inputs are ignored. wd_cnt increments each cycle.
- MEM_WAIT exit on dmem_rvalid_i: in that same cycle all stalls are 0 and the state returns to RUN. wd_cnt clears.
- Watchdog: if wd_cnt reaches MEM_TIMEOUT, mem_timeout_o sets. It stays set until reset. The state is forced to RUN, which releases the pipeline.
- RUN load-use: ex_valid_i && ex_dmem_rd_en_i && ex_rd_addr_i != 0, and ex_rd_addr_i matches a used ID source. Response: stall_if_o=1, squash_id_o=1, stall_id_o=0, for one cycle per detection.
- RUN control hazard (id_ctrl_i only): stall as for load-use when either condition holds:
  - ex_valid_i && ex_reg_wr_en_i && ex_rd_addr_i matches (rd != 0);
  - mem_valid_i && mem_dmem_rd_en_i && mem_rd_addr_i matches (rd != 0).
  A branch behind a load therefore stalls 2 cycles, which comes naturally from re-detection.
- RUN redirect: id_valid_i && id_redirect_i with no hazard -> squash_if_o=1 for one cycle. A redirect during a hazard stall is suppressed and re-evaluated next cycle.
- Hazard checks are qualified by id_valid_i. Register x0 never matches.
- Priority: FLUSH > MEM_WAIT > hazard > redirect.
- Reset asserted mid-MEM_WAIT goes to FLUSH regardless of the outstanding request. The dmem side is reset separately.

Optional Feature:
PIPE_CTRL_PERF_EN. When defined, three PERF_CNT_W-bit outputs are added: perf_hazard_stalls_o, perf_mem_stalls_o, perf_redirects_o.
- They count, respectively, RUN-state hazard stall cycles, MEM_WAIT cycles, and squash_if_o assertions.
- All three clear on reset and saturate at all-ones.
When undefined, the ports and counter logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package util.sv gets ctrl_state_e (FLUSH, RUN, MEM_WAIT) and REG_ZERO = 5'd0.
- One natural sub-module, hazard_detect: purely combinational comparisons that output load_use and ctrl_hazard. The FSM, counters and output muxing stay in pipeline_ctrl.

Test Plan:
- Reset held low 3 cycles then released, RST_FLUSH_CYCLES=2 -> squash_if_o, squash_id_o and stall_if_o high for exactly 2 cycles after release, then all outputs 0.
- EX holds a load to x5 and ID has an add reading x5 as rs2 -> one cycle of stall_if_o=1, squash_id_o=1; next cycle no stall. Same test with rd=x0 -> no stall.
- EX has lw x7 and ID has beq x7,x1 -> 2 consecutive stall cycles (EX-load hit, then MEM-load hit), then the branch proceeds. With ID add-result rd=x7 instead of the load -> 1 stall cycle.
- mem_req_i with dmem_rvalid_i low for 4 cycles -> stall_if/id/mem high 4 cycles, low in the rvalid cycle. rvalid in the same cycle as the request -> no stall.
- MEM_TIMEOUT=8, rvalid never arrives -> mem_timeout_o rises after 8 wait cycles and stays high, and the stalls release.
- id_redirect_i coincides with a load-use hazard -> no squash_if_o that cycle, squash_if_o=1 the cycle after. With PIPE_CTRL_PERF_EN, perf_redirects_o increments by 1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline stall/squash sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    FLUSH    = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A used source register matches a producer destination; x0 never matches.
  function automatic logic src_match(input logic used, input logic [4:0] src,
                                     input logic [4:0] rd);
    return used && (src == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use and control-operand hazard detection for the ID stage.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic       id_ctrl_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_wr_en_i,
  input  logic       ex_dmem_rd_en_i,
  input  logic       mem_valid_i,
  input  logic [4:0] mem_rd_addr_i,
  input  logic       mem_dmem_rd_en_i,
  output logic       load_use,
  output logic       ctrl_hazard
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = src_match(id_rs1_used_i, id_rs1_addr_i, ex_rd_addr_i) ||
                     src_match(id_rs2_used_i, id_rs2_addr_i, ex_rd_addr_i);
  assign mem_match = src_match(id_rs1_used_i, id_rs1_addr_i, mem_rd_addr_i) ||
                     src_match(id_rs2_used_i, id_rs2_addr_i, mem_rd_addr_i);

  assign load_use = id_valid_i && ex_valid_i && ex_dmem_rd_en_i && ex_match;

  // Branches resolve in ID, so they cannot use EX results or a load still in MEM.
  assign ctrl_hazard = id_valid_i && id_ctrl_i &&
                       ((ex_valid_i && ex_reg_wr_en_i && ex_match) ||
                        (mem_valid_i && mem_dmem_rd_en_i && mem_match));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/squash sequencer: post-reset flush, hazard stalls, dmem wait with watchdog.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RST_FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT      = 255
`ifdef PIPE_CTRL_PERF_EN
  ,
  parameter int unsigned PERF_CNT_W       = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic       id_ctrl_i,
  input  logic       id_redirect_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_wr_en_i,
  input  logic       ex_dmem_rd_en_i,
  input  logic       mem_valid_i,
  input  logic [4:0] mem_rd_addr_i,
  input  logic       mem_dmem_rd_en_i,
  input  logic       mem_req_i,
  input  logic       dmem_rvalid_i,
  output logic       stall_if_o,
  output logic       squash_if_o,
  output logic       stall_id_o,
  output logic       squash_id_o,
  output logic       stall_mem_o,
  output logic       mem_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_hazard_stalls_o,
  output logic [PERF_CNT_W-1:0] perf_mem_stalls_o,
  output logic [PERF_CNT_W-1:0] perf_redirects_o
`endif
);

  localparam logic [3:0]  FLUSH_INIT = 4'(RST_FLUSH_CYCLES);
  localparam logic [15:0] WD_LAST    = 16'(MEM_TIMEOUT - 1);

  ctrl_state_e state_reg, state_next;
  logic [3:0]  flush_cnt_reg, flush_cnt_next;
  logic [15:0] wd_cnt_reg, wd_cnt_next;
  logic        timeout_reg, timeout_next;
  logic        load_use;
  logic        ctrl_hazard;
  logic        hazard;

  hazard_detect u_hazard_detect (
    .id_valid_i      (id_valid_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .id_rs1_used_i   (id_rs1_used_i),
    .id_rs2_used_i   (id_rs2_used_i),
    .id_ctrl_i       (id_ctrl_i),
    .ex_valid_i      (ex_valid_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_reg_wr_en_i  (ex_reg_wr_en_i),
    .ex_dmem_rd_en_i (ex_dmem_rd_en_i),
    .mem_valid_i     (mem_valid_i),
    .mem_rd_addr_i   (mem_rd_addr_i),
    .mem_dmem_rd_en_i(mem_dmem_rd_en_i),
    .load_use        (load_use),
    .ctrl_hazard     (ctrl_hazard)
  );

  assign hazard        = load_use || ctrl_hazard;
  assign mem_timeout_o = timeout_reg;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_reg     <= FLUSH;
      flush_cnt_reg <= FLUSH_INIT;
      wd_cnt_reg    <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      flush_cnt_reg <= flush_cnt_next;
      wd_cnt_reg    <= wd_cnt_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    flush_cnt_next = flush_cnt_reg;
    wd_cnt_next    = wd_cnt_reg;
    timeout_next   = timeout_reg;
    case (state_reg)
      FLUSH: begin
        flush_cnt_next = flush_cnt_reg - 4'd1;
        if (flush_cnt_reg <= 4'd1) state_next = RUN;
      end
      RUN: begin
        // A response in the request cycle is a zero-wait access.
        if (mem_valid_i && mem_req_i && !dmem_rvalid_i) begin
          state_next  = MEM_WAIT;
          wd_cnt_next = '0;
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          state_next  = RUN;
          wd_cnt_next = '0;
        end else if (wd_cnt_reg == WD_LAST) begin
          timeout_next = 1'b1;
          state_next   = RUN;
          wd_cnt_next  = '0;
        end else begin
          wd_cnt_next = wd_cnt_reg + 16'd1;
        end
      end
      default: state_next = FLUSH;
    endcase
  end

  always_comb begin
    stall_if_o  = 1'b0;
    squash_if_o = 1'b0;
    stall_id_o  = 1'b0;
    squash_id_o = 1'b0;
    stall_mem_o = 1'b0;
    case (state_reg)
      FLUSH: begin
        stall_if_o  = 1'b1;
        squash_if_o = 1'b1;
        squash_id_o = 1'b1;
      end
      MEM_WAIT: begin
        if (!dmem_rvalid_i) begin
          stall_if_o  = 1'b1;
          stall_id_o  = 1'b1;
          stall_mem_o = 1'b1;
        end
      end
      RUN: begin
        if (hazard) begin
          stall_if_o  = 1'b1;
          squash_id_o = 1'b1;
        end else if (id_valid_i && id_redirect_i) begin
          squash_if_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] perf_hazard_reg, perf_mem_reg, perf_redir_reg;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      perf_hazard_reg <= '0;
      perf_mem_reg    <= '0;
      perf_redir_reg  <= '0;
    end else begin
      if ((state_reg == RUN) && hazard && (perf_hazard_reg != '1))
        perf_hazard_reg <= perf_hazard_reg + 1'b1;
      if (stall_mem_o && (perf_mem_reg != '1))
        perf_mem_reg <= perf_mem_reg + 1'b1;
      if (squash_if_o && (perf_redir_reg != '1))
        perf_redir_reg <= perf_redir_reg + 1'b1;
    end
  end

  assign perf_hazard_stalls_o = perf_hazard_reg;
  assign perf_mem_stalls_o    = perf_mem_reg;
  assign perf_redirects_o     = perf_redir_reg;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl plus hand-written multi-cycle sequences.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       ctrl;
    logic       redirect;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_wr;
    logic       ex_ld;
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_ld;
    logic       mem_req;
    logic       rvalid;
  } in_t;

  typedef struct {
    in_t        in;
    logic [5:0] exp;  // {stall_if, squash_if, stall_id, squash_id, stall_mem, timeout}
    bit         chk;
    string      name;
  } vec_t;

  logic clk;
  in_t  cur;
  logic stall_if, squash_if, stall_id, squash_id, stall_mem, mem_timeout;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_haz, perf_mem, perf_redir;
  logic [31:0] snap_haz, snap_mem, snap_redir;
`endif

  pipeline_ctrl #(
    .RST_FLUSH_CYCLES(2),
    .MEM_TIMEOUT     (8)
  ) dut (
    .clk             (clk),
    .rst_ni          (cur.rst_n),
    .id_valid_i      (cur.id_valid),
    .id_rs1_addr_i   (cur.rs1),
    .id_rs2_addr_i   (cur.rs2),
    .id_rs1_used_i   (cur.rs1_used),
    .id_rs2_used_i   (cur.rs2_used),
    .id_ctrl_i       (cur.ctrl),
    .id_redirect_i   (cur.redirect),
    .ex_valid_i      (cur.ex_valid),
    .ex_rd_addr_i    (cur.ex_rd),
    .ex_reg_wr_en_i  (cur.ex_wr),
    .ex_dmem_rd_en_i (cur.ex_ld),
    .mem_valid_i     (cur.mem_valid),
    .mem_rd_addr_i   (cur.mem_rd),
    .mem_dmem_rd_en_i(cur.mem_ld),
    .mem_req_i       (cur.mem_req),
    .dmem_rvalid_i   (cur.rvalid),
    .stall_if_o      (stall_if),
    .squash_if_o     (squash_if),
    .stall_id_o      (stall_id),
    .squash_id_o     (squash_id),
    .stall_mem_o     (stall_mem),
    .mem_timeout_o   (mem_timeout)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_hazard_stalls_o(perf_haz),
    .perf_mem_stalls_o   (perf_mem),
    .perf_redirects_o    (perf_redir)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t nop();
    in_t v;
    v = '0;
    v.rst_n = 1'b1;
    return v;
  endfunction

  function automatic in_t id_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic u1, input logic u2,
                                   input logic ctrl, input logic redir);
    in_t v;
    v = nop();
    v.id_valid = 1'b1;
    v.rs1 = rs1; v.rs2 = rs2; v.rs1_used = u1; v.rs2_used = u2;
    v.ctrl = ctrl; v.redirect = redir;
    return v;
  endfunction

  function automatic in_t with_ex(input in_t b, input logic [4:0] rd,
                                  input logic wr, input logic ld);
    in_t v;
    v = b;
    v.ex_valid = 1'b1; v.ex_rd = rd; v.ex_wr = wr; v.ex_ld = ld;
    return v;
  endfunction

  function automatic in_t with_mem(input in_t b, input logic [4:0] rd, input logic ld,
                                   input logic req, input logic rvalid);
    in_t v;
    v = b;
    v.mem_valid = 1'b1; v.mem_rd = rd; v.mem_ld = ld;
    v.mem_req = req; v.rvalid = rvalid;
    return v;
  endfunction

  function automatic in_t in_reset();
    in_t v;
    v = '0;
    return v;
  endfunction

  task automatic add(input string name, input in_t v, input logic [5:0] e, input bit c);
    vec_t t;
    t.in = v; t.exp = e; t.chk = c; t.name = name;
    vecs.push_back(t);
  endtask

  task automatic step(input in_t v);
    @(negedge clk);
    cur = v;
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] e);
    logic [5:0] act;
    act = {stall_if, squash_if, stall_id, squash_id, stall_mem, mem_timeout};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, e);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, e);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    cur = '0;

    add("rst_first",   in_reset(), 6'b000000, 1'b0);
    add("rst_hold1",   in_reset(), 6'b110100, 1'b1);
    add("rst_hold2",   in_reset(), 6'b110100, 1'b1);
    add("flush1",      nop(),      6'b110100, 1'b1);
    add("flush2",      nop(),      6'b110100, 1'b1);
    add("run_idle",    nop(),      6'b000000, 1'b1);
    add("lu_x5_rs2",   with_ex(id_instr(5'd1, 5'd5, 1, 1, 0, 0), 5'd5, 1, 1), 6'b100100, 1'b1);
    add("lu_after",    with_mem(id_instr(5'd1, 5'd5, 1, 1, 0, 0), 5'd5, 1, 0, 0), 6'b000000, 1'b1);
    add("lu_x0",       with_ex(id_instr(5'd0, 5'd0, 1, 1, 0, 0), 5'd0, 1, 1), 6'b000000, 1'b1);
    add("lu_unused",   with_ex(id_instr(5'd1, 5'd5, 1, 0, 0, 0), 5'd5, 1, 1), 6'b000000, 1'b1);
    add("br_ld_ex",    with_ex(id_instr(5'd7, 5'd1, 1, 1, 1, 0), 5'd7, 1, 1), 6'b100100, 1'b1);
    add("br_ld_mem",   with_mem(id_instr(5'd7, 5'd1, 1, 1, 1, 0), 5'd7, 1, 0, 0), 6'b100100, 1'b1);
    add("br_ld_go",    id_instr(5'd7, 5'd1, 1, 1, 1, 0), 6'b000000, 1'b1);
    add("br_add_ex",   with_ex(id_instr(5'd7, 5'd1, 1, 1, 1, 0), 5'd7, 1, 0), 6'b100100, 1'b1);
    add("br_add_mem",  with_mem(id_instr(5'd7, 5'd1, 1, 1, 1, 0), 5'd7, 0, 0, 0), 6'b000000, 1'b1);
    add("alu_add_ex",  with_ex(id_instr(5'd7, 5'd1, 1, 1, 0, 0), 5'd7, 1, 0), 6'b000000, 1'b1);
    add("redirect",    id_instr(5'd0, 5'd0, 0, 0, 0, 1), 6'b010000, 1'b1);
    add("redir_inval", with_ex(nop(), 5'd3, 1, 0), 6'b000000, 1'b1);
    add("mem_zero_wt", with_mem(nop(), 5'd3, 1, 1, 1), 6'b000000, 1'b1);
    add("mem_zero_nx", nop(), 6'b000000, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in);
      if (vecs[i].chk) check(vecs[i].name, vecs[i].exp);
    end
    vecs[17].in.redirect = 1'b1;  // redirect flag without id_valid must not squash
    step(vecs[17].in);
    check("redir_no_valid", 6'b000000);

    // Four-cycle dmem wait; hazard inputs present during the wait are ignored.
`ifdef PIPE_CTRL_PERF_EN
    snap_mem = perf_mem;
`endif
    step(with_mem(nop(), 5'd3, 1, 1, 0));
    check("mw_req", 6'b000000);
    for (int i = 0; i < 4; i++) begin
      step(with_mem(with_ex(id_instr(5'd5, 5'd0, 1, 0, 0, 1), 5'd5, 1, 1), 5'd3, 1, 0, 0));
      check($sformatf("mw_wait%0d", i), 6'b101010);
    end
    step(with_mem(with_ex(id_instr(5'd5, 5'd0, 1, 0, 0, 1), 5'd5, 1, 1), 5'd3, 1, 0, 1));
    check("mw_rvalid", 6'b000000);
    step(nop());
    check("mw_after", 6'b000000);
`ifdef PIPE_CTRL_PERF_EN
    check_val("perf_mem_4", perf_mem - snap_mem, 32'd4);
`endif

    // Redirect colliding with a load-use stall is deferred by one cycle.
`ifdef PIPE_CTRL_PERF_EN
    snap_haz   = perf_haz;
    snap_redir = perf_redir;
`endif
    step(with_ex(id_instr(5'd5, 5'd0, 1, 0, 0, 1), 5'd5, 1, 1));
    check("rd_lu_hold", 6'b100100);
    step(with_mem(id_instr(5'd5, 5'd0, 1, 0, 0, 1), 5'd5, 1, 0, 0));
    check("rd_lu_squash", 6'b010000);
    step(nop());
    check("rd_lu_after", 6'b000000);
`ifdef PIPE_CTRL_PERF_EN
    check_val("perf_redir_1", perf_redir - snap_redir, 32'd1);
    check_val("perf_haz_1", perf_haz - snap_haz, 32'd1);
`endif

    // Watchdog: no response for MEM_TIMEOUT=8 wait cycles.
    step(with_mem(nop(), 5'd2, 1, 1, 0));
    check("wd_req", 6'b000000);
    for (int i = 0; i < 8; i++) begin
      step(nop());
      check($sformatf("wd_wait%0d", i), 6'b101010);
    end
    for (int i = 0; i < 3; i++) begin
      step(nop());
      check($sformatf("wd_fired%0d", i), 6'b000001);
    end

    // Reset asserted mid-wait flushes and clears the sticky timeout.
    step(with_mem(nop(), 5'd2, 1, 1, 0));
    check("rw_req", 6'b000001);
    step(nop());
    check("rw_wait", 6'b101011);
    step(in_reset());
    check("rw_rst_edge", 6'b101011);
    step(in_reset());
    check("rw_rst_flush", 6'b110100);
    step(nop());
    check("rw_flush1", 6'b110100);
    step(nop());
    check("rw_flush2", 6'b110100);
    step(nop());
    check("rw_run", 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
